// File: rtl/sram_pkg.sv
// Shared types and helpers for the SRAM responder slice.
// Pin-level widths, FSM state encoding and the byte-lane strobe decode.
package sram_pkg;

   localparam int SRAM_DATA_W = 16;
   localparam int SRAM_ADDR_W = 18;
   localparam int BYTE_W      = 8;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_DRIVE
   } state_t;

   // Active-low lane pins to an active-high strobe, bit 1 = [15:8].
   function automatic logic [1:0] lane_mask(
      input logic ub_n,
      input logic lb_n
   );
      return {~ub_n, ~lb_n};
   endfunction

endpackage

// File: rtl/sram_word_array.sv
// Byte-strobed single-port word storage for the SRAM responder.
// Synchronous write, asynchronous read; contents are never reset.
module sram_word_array
   import sram_pkg::*;
#(
   parameter int DEPTH_LOG2 = 16,
   parameter int DATA_W     = SRAM_DATA_W
) (
   input  logic                  clk,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic                  we,
   input  logic [1:0]            strb,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 2; i++) begin
            if (strb[i]) begin
               mem[addr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/sram_responder.sv
// Cycle-based model of the external 16-bit asynchronous SRAM.
// Wait-stated reads, byte-masked writes, registered tri-state DQ.
module sram_responder
   import sram_pkg::*;
#(
   parameter int ADDR_W     = SRAM_ADDR_W,
   parameter int DATA_W     = SRAM_DATA_W,
   parameter int DEPTH_LOG2 = 16,
   parameter int READ_LAT   = 2,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] SRAM_ADDR,
   inout  wire  [DATA_W-1:0] SRAM_DQ,
   input  logic              SRAM_WE_N,
   input  logic              SRAM_OE_N,
   input  logic              SRAM_CE_N,
   input  logic              SRAM_UB_N,
   input  logic              SRAM_LB_N,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic              conflict
);

   localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

   state_t            state;
   state_t            nxt;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        cnt_q;
   logic              dq_oe;
   logic [DATA_W-1:0] dq_q;
   logic              drive_d;
   logic [DATA_W-1:0] dq_d;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        lanes;
   logic              wr_req;
   logic              rd_req;
   logic              addr_chg;
   logic              load;
   logic              enter;

   assign wr_req   = ~SRAM_CE_N & ~SRAM_WE_N;
   assign rd_req   = ~SRAM_CE_N & SRAM_WE_N & ~SRAM_OE_N;
   assign addr_chg = SRAM_ADDR != addr_q;
   assign lanes    = lane_mask(SRAM_UB_N, SRAM_LB_N);
   assign load     = rd_req & ~wr_req & ((state == IDLE) | addr_chg);

   sram_word_array #(
      .DEPTH_LOG2(DEPTH_LOG2),
      .DATA_W    (DATA_W)
   ) u_array (
      .clk  (clk),
      .addr (SRAM_ADDR[DEPTH_LOG2-1:0]),
      .we   (wr_req),
      .strb (lanes),
      .wdata(SRAM_DQ),
      .rdata(rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         addr_q   <= '0;
         cnt_q    <= '0;
         dq_oe    <= 1'b0;
         dq_q     <= '0;
         rd_cnt   <= '0;
         wr_cnt   <= '0;
         conflict <= 1'b0;
      end else begin
         state <= nxt;
         dq_oe <= drive_d;
         dq_q  <= dq_d;
         if (load) begin
            addr_q <= SRAM_ADDR;
            cnt_q  <= LAT_M1;
         end else if (state == RD_WAIT && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 1'b1;
         end
         if (enter) begin
            rd_cnt <= rd_cnt + 1'b1;
         end
         if (wr_req) begin
            wr_cnt <= wr_cnt + 1'b1;
         end
         if (wr_req & ~SRAM_OE_N) begin
            conflict <= 1'b1;
         end
      end
   end

   // A write in any state wins and parks the FSM in IDLE.
   always_comb begin
      nxt = state;
      if (wr_req) begin
         nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (rd_req) begin
                  nxt = (READ_LAT == 1) ? RD_DRIVE : RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (!rd_req) begin
                  nxt = IDLE;
               end else if (addr_chg) begin
                  nxt = RD_WAIT;
               end else if (cnt_q == 4'd0) begin
                  nxt = RD_DRIVE;
               end
            end
            RD_DRIVE: begin
               if (!rd_req) begin
                  nxt = IDLE;
               end else if (addr_chg) begin
                  nxt = RD_WAIT;
               end
            end
            default: nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      drive_d = 1'b0;
      dq_d    = '0;
      if (nxt == RD_DRIVE) begin
         drive_d = 1'b1;
         dq_d    = {rdata[2*BYTE_W-1:BYTE_W] & {BYTE_W{lanes[1]}},
                    rdata[BYTE_W-1:0]        & {BYTE_W{lanes[0]}}};
      end
   end

   assign enter   = drive_d & (state != RD_DRIVE);
   assign SRAM_DQ = dq_oe ? dq_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: stimulus queues expected DQ
// words, a negedge monitor pops and compares on every driven cycle.
module tb_sram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] addr;
   wire  [15:0] dq;
   logic        we_n, oe_n, ce_n, ub_n, lb_n;
   logic        tb_drv;
   logic [15:0] tb_dq;
   logic [15:0] rd_cnt, wr_cnt;
   logic        conflict;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [15:0] exp_q[$];

   always #5 clk = ~clk;

   assign dq = tb_drv ? tb_dq : 16'hzzzz;

   sram_responder dut (
      .clk      (clk),
      .rst      (rst),
      .SRAM_ADDR(addr),
      .SRAM_DQ  (dq),
      .SRAM_WE_N(we_n),
      .SRAM_OE_N(oe_n),
      .SRAM_CE_N(ce_n),
      .SRAM_UB_N(ub_n),
      .SRAM_LB_N(lb_n),
      .rd_cnt   (rd_cnt),
      .wr_cnt   (wr_cnt),
      .conflict (conflict)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic c, input logic w, input logic o,
                       input logic u, input logic l,
                       input logic [17:0] a, input logic [15:0] d);
      ce_n   = c;
      we_n   = w;
      oe_n   = o;
      ub_n   = u;
      lb_n   = l;
      addr   = a;
      tb_dq  = d;
      tb_drv = ~c & ~w;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [17:0] a, input logic u, input logic l);
      step(1'b0, 1'b1, 1'b0, u, l, a, 16'h0000);
   endtask

   task automatic wr(input logic [17:0] a, input logic [15:0] d,
                     input logic u, input logic l);
      step(1'b0, 1'b0, 1'b1, u, l, a, d);
   endtask

   task automatic idle();
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'h0, 16'h0000);
   endtask

   task automatic chk_z(input string name);
      check(name, 32'(dut.dq_oe), 32'd0);
   endtask

   // Monitor: every driven cycle must match the next queued word.
   always @(negedge clk) begin
      if (dut.dq_oe === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_drive: dq=%h, none expected", dq);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (dq !== e) begin
               n_fail++;
               $display("FAIL read_data: got %h expected %h", dq, e);
            end
         end
      end
   end

   initial begin
      rst = 1'b0;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h0, 16'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h0, 16'h0);
      chk_z("reset_dq");
      check("reset_rd_cnt", 32'(rd_cnt), 32'd0);
      check("reset_wr_cnt", 32'(wr_cnt), 32'd0);
      check("reset_conflict", 32'(conflict), 32'd0);
      idle();
      rst = 1'b1;
      idle();

      wr(18'h00010, 16'hBEEF, 1'b0, 1'b0);
      rd(18'h00010, 1'b0, 1'b0);
      chk_z("lat_cycle1");
      rd(18'h00010, 1'b0, 1'b0);
      chk_z("lat_cycle2");
      exp_q.push_back(16'hBEEF);
      rd(18'h00010, 1'b0, 1'b0);
      exp_q.push_back(16'hBEEF);
      rd(18'h00010, 1'b0, 1'b0);
      idle();
      chk_z("release_idle");
      check("rd_cnt_1", 32'(rd_cnt), 32'd1);
      check("wr_cnt_1", 32'(wr_cnt), 32'd1);

      wr(18'h5, 16'h1234, 1'b0, 1'b0);
      wr(18'h5, 16'hAB00, 1'b0, 1'b1);
      rd(18'h5, 1'b0, 1'b0);
      rd(18'h5, 1'b0, 1'b0);
      exp_q.push_back(16'hAB34);
      rd(18'h5, 1'b0, 1'b0);
      exp_q.push_back(16'h0034);
      rd(18'h5, 1'b1, 1'b0);
      idle();
      check("rd_cnt_2", 32'(rd_cnt), 32'd2);
      check("wr_cnt_3", 32'(wr_cnt), 32'd3);

      rd(18'h5, 1'b0, 1'b0);
      rd(18'h5, 1'b0, 1'b0);
      exp_q.push_back(16'hAB34);
      rd(18'h5, 1'b0, 1'b0);
      rd(18'h10, 1'b0, 1'b0);
      chk_z("b2b_release");
      rd(18'h10, 1'b0, 1'b0);
      chk_z("b2b_wait");
      exp_q.push_back(16'hBEEF);
      rd(18'h10, 1'b0, 1'b0);
      idle();
      check("rd_cnt_b2b", 32'(rd_cnt), 32'd4);

      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h7, 16'h5A5A);
      chk_z("conflict_no_drive");
      check("conflict_set", 32'(conflict), 32'd1);
      idle();
      rd(18'h7, 1'b0, 1'b0);
      rd(18'h7, 1'b0, 1'b0);
      exp_q.push_back(16'h5A5A);
      rd(18'h7, 1'b0, 1'b0);
      idle();
      check("conflict_sticky", 32'(conflict), 32'd1);
      check("wr_cnt_4", 32'(wr_cnt), 32'd4);
      check("rd_cnt_5", 32'(rd_cnt), 32'd5);

      rd(18'h10, 1'b0, 1'b0);
      wr(18'h10, 16'h1111, 1'b0, 1'b0);
      chk_z("write_aborts_read");
      wr(18'h10, 16'hFFFF, 1'b1, 1'b1);
      check("wr_cnt_no_lanes", 32'(wr_cnt), 32'd6);
      rd(18'h10, 1'b0, 1'b0);
      rd(18'h10, 1'b0, 1'b0);
      exp_q.push_back(16'h1111);
      rd(18'h10, 1'b0, 1'b0);
      idle();
      check("rd_cnt_6", 32'(rd_cnt), 32'd6);

      wr(18'h10005, 16'hC0DE, 1'b0, 1'b0);
      rd(18'h5, 1'b0, 1'b0);
      rd(18'h5, 1'b0, 1'b0);
      exp_q.push_back(16'hC0DE);
      rd(18'h5, 1'b0, 1'b0);
      rst = 1'b0;
      rd(18'h5, 1'b0, 1'b0);
      chk_z("reset_mid_read");
      check("reset2_rd_cnt", 32'(rd_cnt), 32'd0);
      check("reset2_wr_cnt", 32'(wr_cnt), 32'd0);
      check("reset2_conflict", 32'(conflict), 32'd0);
      rst = 1'b1;
      rd(18'h5, 1'b0, 1'b0);
      rd(18'h5, 1'b0, 1'b0);
      exp_q.push_back(16'hC0DE);
      rd(18'h5, 1'b0, 1'b0);
      idle();
      check("rd_cnt_after_reset", 32'(rd_cnt), 32'd1);
      idle();

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Cycle-based, synthesizable model of the external 16-bit asynchronous SRAM chip: the responder end of the SRAM pin interface the MEM stage drives.
- Answers reads after a programmable wait-state count, commits byte-masked writes, and owns the tri-state SRAM_DQ bus.
- Sits in the system testbench and FPGA self-test builds in place of the physical SRAM.
- Exposes access counters and a conflict flag for verification.

Parameters:
ADDR_W, 18, SRAM_ADDR width (word address)
DATA_W, 16, SRAM_DQ width; must be 16 (two byte lanes)
DEPTH_LOG2, 16, implemented words = 2**DEPTH_LOG2; upper address bits ignored (alias)
READ_LAT, 2, cycles from read request to valid DQ drive; legal 1..15
CNT_W, 16, width of access counters

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
SRAM_ADDR  input  ADDR_W  word address from initiator
SRAM_DQ  inout  DATA_W  bidirectional data; driven only in RD_DRIVE
SRAM_WE_N  input  1  write enable, active-low
SRAM_OE_N  input  1  output enable, active-low
SRAM_CE_N  input  1  chip enable, active-low
SRAM_UB_N  input  1  upper byte lane [15:8] enable, active-low
SRAM_LB_N  input  1  lower byte lane [7:0] enable, active-low
rd_cnt  output  CNT_W  completed reads (first drive cycle of each address)
wr_cnt  output  CNT_W  committed writes
conflict  output  1  sticky: WE_N and OE_N both low with CE_N low

Behaviour:
- Reset (rst==0 at clk edge): state IDLE, DQ released (Z), wait counter 0, rd_cnt=0, wr_cnt=0, conflict=0. Memory contents are NOT cleared. Reset mid-read releases DQ at that edge.
- All pin inputs are sampled at posedge clk; DQ drive enable and data are registered (no combinational pin-to-pin paths).
- Selected = CE_N==0. Write request = selected & WE_N==0. Read request = selected & WE_N==1 & OE_N==0.
- Write priority: a write request in any state commits at that edge. mem[addr][7:0] is written if LB_N==0; mem[addr][15:8] is written if UB_N==0. Both lanes high means no store, but wr_cnt still increments. DQ is released at the same edge and state becomes IDLE. The write aborts any pending read.
- conflict is set when WE_N==0 & OE_N==0 & CE_N==0. It clears only on reset.
- States:
  - IDLE: on read request, latch addr, load wait counter = READ_LAT-1, go to RD_WAIT. If READ_LAT==1, go directly to RD_DRIVE.
  - RD_WAIT: DQ is Z. The counter decrements each cycle. A read request with changed addr re-latches and reloads. Loss of read request goes to IDLE. At counter==0 with the read request held, go to RD_DRIVE; the next cycle drives data.
  - RD_DRIVE: DQ = mem[latched addr] per lane. A lane with its byte enable high drives 8'h00. rd_cnt increments once on entry. Same addr and request held: stay, keep driving. Addr change: release DQ, re-latch, go to RD_WAIT. Request dropped (CE_N, OE_N high, or WE_N low): release DQ at that edge, go to IDLE (or handle the write).
- Address aliasing: only SRAM_ADDR[DEPTH_LOG2-1:0] indexes storage.
- Counters wrap modulo 2**CNT_W with no saturation.
- Simultaneous read-address change and write: the write wins, per the priority rule.

Decomposition:
- Shared package sram_pkg:
  - state enum {IDLE, RD_WAIT, RD_DRIVE}
  - localparams SRAM_DATA_W=16, SRAM_ADDR_W=18, BYTE_W=8
  - function lane_mask(ub_n, lb_n) returning 2-bit write strobe
- Sub-module sram_word_array:
  - byte-strobed, single-port, synchronous write and asynchronous read storage (DEPTH_LOG2, 2 lanes).
  - Instantiated once; the FSM, wait counter, DQ tri-state and counters stay in sram_responder.

Test Plan:
- Reset with rst=0 for 2 cycles while OE_N=0, CE_N=0 -> DQ stays Z, rd_cnt=0, wr_cnt=0, conflict=0.
- Write addr 18'h00010 data 16'hBEEF with UB_N=LB_N=0, then read the same addr with READ_LAT=2 -> DQ Z for 2 cycles, 16'hBEEF driven on cycle 3 after the request; rd_cnt=1, wr_cnt=1.
- Byte lanes: write 16'h1234 to addr 5, then 16'hAB00 with UB_N=0, LB_N=1, then read with LB_N=0, UB_N=0 -> 16'hAB34. Read again with UB_N=1 -> 16'h0034.
- Back-to-back reads: addr 5 then addr 16 while OE_N stays low -> DQ released after the addr change, data for addr 16 appears READ_LAT+1 cycles later; rd_cnt increments by exactly 1 per address.
- Conflict: CE_N=0, OE_N=0, WE_N=0, addr 7, data 16'h5A5A -> write commits (readback 16'h5A5A), DQ never driven during the conflict cycle, conflict=1 until rst=0.
- Reset mid-read (state RD_DRIVE, DQ driving) -> DQ Z after the reset edge; memory contents preserved on the following read; aliasing check: write addr 18'h10005 is read back at addr 18'h00005 with DEPTH_LOG2=16.
